sd_bd_ram: RTL and testbench

SD host controller buffer-descriptor (BD) store, sitting between the bus-side BD register port (master) and the data-transfer engine (slave). The master pushes two-word descriptors, and the slave pops them one word at a time through a request/acknowledge handshake. The slave returns completion pulses that release descriptor slots. `free_bd` reports to software how many descriptor slots can still be written.

---
 rtl/sd_bd_ram_if.sv | 24 ++
 rtl/sd_bd_ram.sv | 113 +++++++++++
 tb/tb_sd_bd_ram.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/sd_bd_ram_if.sv
// Bus bundle between the BD register port, the descriptor store and the data-transfer engine.
// Modports are the store's view of each side: master = BD register port, slave = transfer engine.
`ifndef RAM_MEM_WIDTH
`define RAM_MEM_WIDTH 32
`endif
`ifndef BD_WIDTH
`define BD_WIDTH 5
`endif

interface sd_bd_ram_if #(
   parameter int DW = `RAM_MEM_WIDTH,
   parameter int BW = `BD_WIDTH
);
   logic          we_m;
   logic [DW-1:0] dat_in_m;
   logic [BW-1:0] free_bd;
   logic          re_s;
   logic          ack_o_s;
   logic          a_cmp;
   logic [DW-1:0] dat_out_s;

   modport master (input we_m, input dat_in_m, output free_bd);
   modport slave  (input re_s, input a_cmp, output ack_o_s, output dat_out_s);
endinterface

// File: rtl/sd_bd_ram.sv
// SD host buffer-descriptor store: circular word RAM with write/commit/read pointers.
// Optional build macro SD_BD_CLEAR_ON_RESET_EN also zeroes every RAM word during reset.
`ifndef RAM_MEM_WIDTH
`define RAM_MEM_WIDTH 32
`endif
`ifndef BD_WIDTH
`define BD_WIDTH 5
`endif

module sd_bd_ram (
   input  logic        clk,
   input  logic        rst,
   sd_bd_ram_if.master m_if,
   sd_bd_ram_if.slave  s_if
);
   localparam int DW     = `RAM_MEM_WIDTH;
   localparam int BW     = `BD_WIDTH;
   localparam int PW     = BW + 1;
   localparam int NBD    = 2 ** (BW - 1);
   localparam int NWORDS = 2 * NBD;
   localparam logic [BW-1:0] NBD_C = BW'(NBD);

   logic [DW-1:0] mem_q [NWORDS];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] cmt_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic          phase_q;
   logic [BW-1:0] free_q;
   logic [BW-1:0] free_d;
   logic          ack_q;
   logic [DW-1:0] dat_q;
   logic          a_cmp_q;

   logic          wr_acc;
   logic          commit;
   logic          release_evt;
   logic          rd_fire;
   logic [BW-1:0] wr_addr;
   logic [BW-1:0] rd_addr;
   logic          unused_wr_msb;

   assign wr_addr       = wr_ptr_q[BW-1:0];
   assign rd_addr       = rd_ptr_q[BW-1:0];
   assign unused_wr_msb = wr_ptr_q[BW];

   // Only words behind the commit pointer are readable, so half descriptors stay hidden.
   always_comb begin
      wr_acc      = m_if.we_m && (free_q != '0);
      commit      = wr_acc && phase_q;
      release_evt = s_if.a_cmp && !a_cmp_q;
      rd_fire     = s_if.re_s && !ack_q && (rd_ptr_q != cmt_ptr_q);
   end

   always_comb begin
      free_d = free_q;
      if (commit && !release_evt) begin
         free_d = free_q - 1'b1;
      end else if (release_evt && !commit && (free_q != NBD_C)) begin
         free_d = free_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q  <= '0;
         cmt_ptr_q <= '0;
         rd_ptr_q  <= '0;
         phase_q   <= 1'b0;
         free_q    <= NBD_C;
         ack_q     <= 1'b0;
         dat_q     <= '0;
         a_cmp_q   <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
            phase_q  <= ~phase_q;
         end
         if (commit) begin
            cmt_ptr_q <= cmt_ptr_q + PW'(2);
         end
         free_q  <= free_d;
         a_cmp_q <= s_if.a_cmp;
         ack_q   <= rd_fire;
         if (rd_fire) begin
            dat_q    <= mem_q[rd_addr];
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
      end
   end

`ifdef SD_BD_CLEAR_ON_RESET_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NWORDS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_acc) begin
         mem_q[wr_addr] <= m_if.dat_in_m;
      end
   end
`else
   // No reset on the array so it can map onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem_q[wr_addr] <= m_if.dat_in_m;
      end
   end
`endif

   assign m_if.free_bd   = free_q;
   assign s_if.ack_o_s   = ack_q;
   assign s_if.dat_out_s = dat_q;
endmodule

// File: tb/tb_sd_bd_ram.sv
// Directed + randomized bench for sd_bd_ram against a queue-based descriptor model.
module tb_sd_bd_ram;
   localparam int NBD = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   sd_bd_ram_if bus ();

   sd_bd_ram dut (
      .clk  (clk),
      .rst  (rst),
      .m_if (bus),
      .s_if (bus)
   );

   int          tests = 0;
   int          fails = 0;
   int          free_m;
   bit          phase_m;
   logic [31:0] pend_m;
   logic [31:0] rdq[$];
   bit          ack_m;
   logic [31:0] dat_m;
   bit          acmp_prev_m;
   int          commits_m;
   int          words_read;
   int          released;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Model: readable words are a FIFO of committed descriptor words; free is a slot count.
   task automatic step(input bit we, input logic [31:0] din, input bit re, input bit ac);
      bit acc, cmt, rel;
      acc = we && (free_m != 0);
      cmt = acc && phase_m;
      rel = ac && !acmp_prev_m;
      if (re && !ack_m && rdq.size() > 0) begin
         ack_m = 1'b1;
         dat_m = rdq.pop_front();
         words_read++;
      end else begin
         ack_m = 1'b0;
      end
      if (acc) begin
         if (!phase_m) pend_m = din;
         else begin
            rdq.push_back(pend_m);
            rdq.push_back(din);
            commits_m++;
         end
         phase_m = !phase_m;
      end
      if (cmt && !rel) free_m--;
      else if (rel && !cmt && free_m < NBD) free_m++;
      acmp_prev_m = ac;

      bus.we_m     = we;
      bus.dat_in_m = din;
      bus.re_s     = re;
      bus.a_cmp    = ac;
      @(posedge clk);
      #1;
      chk("ack_o_s", {31'd0, bus.ack_o_s}, {31'd0, ack_m});
      chk("dat_out_s", bus.dat_out_s, dat_m);
      chk("free_bd", {27'd0, bus.free_bd}, free_m);
      if (bus.ack_o_s) $display("[TB] ack word %h (expected %h)", bus.dat_out_s, dat_m);
   endtask

   task automatic do_reset();
      rst          = 1'b0;
      bus.we_m     = 1'b0;
      bus.dat_in_m = '0;
      bus.re_s     = 1'b0;
      bus.a_cmp    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      free_m      = NBD;
      phase_m     = 1'b0;
      pend_m      = '0;
      rdq.delete();
      ack_m       = 1'b0;
      dat_m       = '0;
      acmp_prev_m = 1'b0;
      chk("rst_free_bd", {27'd0, bus.free_bd}, 32'd16);
      chk("rst_ack", {31'd0, bus.ack_o_s}, 32'd0);
      chk("rst_dat", bus.dat_out_s, 32'd0);
   endtask

   task automatic write_desc(input logic [31:0] w0, input logic [31:0] w1);
      step(1'b1, w0, 1'b0, 1'b0);
      step(1'b1, w1, 1'b0, 1'b0);
   endtask

   task automatic pulse_release();
      step(1'b0, '0, 1'b0, 1'b1);
      step(1'b0, '0, 1'b0, 1'b0);
   endtask

   int cyc;
   bit we_r;
   bit ac_r;

   initial begin
      commits_m  = 0;
      words_read = 0;
      released   = 0;
      do_reset();

      // read request with nothing written
      repeat (3) step(1'b0, '0, 1'b1, 1'b0);

      // single descriptor
      write_desc(32'h1000_0000, 32'h0000_0042);
      chk("single_free", {27'd0, bus.free_bd}, 32'd15);
      repeat (4) step(1'b0, '0, 1'b1, 1'b0);

      // held a_cmp counts once (14 -> 15, not 16)
      write_desc($urandom, $urandom);
      repeat (4) step(1'b0, '0, 1'b1, 1'b0);
      repeat (5) step(1'b0, '0, 1'b0, 1'b1);
      step(1'b0, '0, 1'b0, 1'b0);
      chk("held_acmp_free", {27'd0, bus.free_bd}, 32'd15);
      pulse_release();
      pulse_release();
      chk("sat_free", {27'd0, bus.free_bd}, 32'd16);

      // full store, then an ignored extra write
      for (int i = 0; i < NBD; i++) write_desc($urandom, $urandom);
      chk("full_free", {27'd0, bus.free_bd}, 32'd0);
      step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
      repeat (66) step(1'b0, '0, 1'b1, 1'b0);
      for (int i = 0; i < NBD; i++) pulse_release();

      // commit coincident with a_cmp edge
      write_desc($urandom, $urandom);
      repeat (4) step(1'b0, '0, 1'b1, 1'b0);
      step(1'b1, $urandom, 1'b0, 1'b0);
      step(1'b1, $urandom, 1'b0, 1'b1);
      step(1'b0, '0, 1'b0, 1'b0);
      chk("coincident_free", {27'd0, bus.free_bd}, 32'd15);
      repeat (4) step(1'b0, '0, 1'b1, 1'b0);
      pulse_release();
      pulse_release();

      // pending read served after commit
      repeat (2) step(1'b0, '0, 1'b1, 1'b0);
      step(1'b1, 32'hA5A5_0001, 1'b1, 1'b0);
      step(1'b1, 32'hA5A5_0002, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      chk("pending_ack1", {31'd0, bus.ack_o_s}, 32'd1);
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      chk("pending_ack2", bus.dat_out_s, 32'hA5A5_0002);
      step(1'b0, '0, 1'b0, 1'b0);
      pulse_release();

      // randomized traffic across the pointer wrap
      commits_m  = 0;
      words_read = 0;
      released   = 0;
      cyc        = 0;
      while (cyc < 3000 && !(commits_m >= 40 && rdq.size() == 0 && !phase_m)) begin
         we_r = phase_m ? 1'b1 : (commits_m < 40 && $urandom_range(0, 2) != 0);
         ac_r = 1'b0;
         if (!acmp_prev_m && (words_read / 2 - released) > 0 && $urandom_range(0, 1) == 1) begin
            ac_r = 1'b1;
            released++;
         end
         step(we_r, $urandom, $urandom_range(0, 3) != 0, ac_r);
         cyc++;
      end
      chk("wrap_done_in_budget", {31'd0, cyc < 3000}, 32'd1);
      step(1'b0, '0, 1'b0, 1'b0);

      // reset after a lone word 0
      step(1'b1, 32'h0BAD_0000, 1'b0, 1'b0);
      do_reset();
      write_desc(32'h2000_0000, 32'h0000_0077);
      repeat (4) step(1'b0, '0, 1'b1, 1'b0);
      chk("post_reset_word1", bus.dat_out_s, 32'h0000_0077);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
